// File: rtl/log_perf_ctrl.sv
// Log/perf control source: free-running cycle timer, windowed log enable, and
// one-cycle perf dump/clean strobes, always sequenced dump before clean.
module log_perf_ctrl #(
  parameter int TIMER_W    = 64,
  parameter int INTERVAL_W = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  timer_en,
  input  logic [TIMER_W-1:0]    log_begin,
  input  logic [TIMER_W-1:0]    log_end,
  input  logic [INTERVAL_W-1:0] perf_interval,
  input  logic                  perf_dump_req,
  input  logic                  perf_clean_req,
  output logic [TIMER_W-1:0]    timer,
  output logic                  log_enable,
  output logic                  perf_clean,
  output logic                  perf_dump,
  output logic                  perf_busy
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_DUMP  = 2'd1;
  localparam logic [1:0] ST_CLEAN = 2'd2;

  logic [1:0]            state;
  logic [1:0]            state_next;
  logic [TIMER_W-1:0]    timer_q;
  logic [TIMER_W-1:0]    timer_next;
  logic [INTERVAL_W-1:0] ival_cnt;
  logic [INTERVAL_W-1:0] ival_cnt_next;
  logic                  dump_pend;
  logic                  clean_pend;
  logic                  dump_pend_next;
  logic                  clean_pend_next;
  logic                  periodic_fire;
  logic                  dump_want;
  logic                  clean_want;
  logic                  log_enable_next;

  assign timer = timer_q;

  // NOTE: each always_comb output is given a default first, so no path leaves it unassigned and infers a latch.
  always_comb begin
    timer_next = timer_q;
    if (timer_en && (timer_q != '1)) timer_next = timer_q + TIMER_W'(1);
  end

  // Registered from the next timer value so log_enable lines up with the timer it describes.
  assign log_enable_next = (timer_next >= log_begin) && (timer_next < log_end);

  assign periodic_fire = timer_en && (perf_interval != '0) &&
                         (ival_cnt >= perf_interval - INTERVAL_W'(1));

  always_comb begin
    ival_cnt_next = ival_cnt;
    if (perf_interval == '0)  ival_cnt_next = '0;
    else if (periodic_fire)   ival_cnt_next = '0;
    else if (timer_en)        ival_cnt_next = ival_cnt + INTERVAL_W'(1);
  end

  assign dump_want  = dump_pend  | perf_dump_req  | periodic_fire;
  assign clean_want = clean_pend | perf_clean_req | periodic_fire;

  // A flag is consumed while its strobe is high; a request landing in that cycle re-arms it.
  assign dump_pend_next  = (dump_pend  & (state != ST_DUMP))  | perf_dump_req  | periodic_fire;
  assign clean_pend_next = (clean_pend & (state != ST_CLEAN)) | perf_clean_req | periodic_fire;

  always_comb begin
    state_next = ST_IDLE;
    case (state)
      ST_IDLE: begin
        if (dump_want)       state_next = ST_DUMP;
        else if (clean_want) state_next = ST_CLEAN;
      end
      ST_DUMP: begin
        if (clean_want)      state_next = ST_CLEAN;
      end
      default:               state_next = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock) begin
    if (!reset) begin
      timer_q    <= '0;
      ival_cnt   <= '0;
      dump_pend  <= 1'b0;
      clean_pend <= 1'b0;
      state      <= ST_IDLE;
      log_enable <= 1'b0;
      perf_dump  <= 1'b0;
      perf_clean <= 1'b0;
    end else begin
      timer_q    <= timer_next;
      ival_cnt   <= ival_cnt_next;
      dump_pend  <= dump_pend_next;
      clean_pend <= clean_pend_next;
      state      <= state_next;
      log_enable <= log_enable_next;
      perf_dump  <= (state_next == ST_DUMP);
      perf_clean <= (state_next == ST_CLEAN);
    end
  end

  assign perf_busy = (state != ST_IDLE) | dump_pend | clean_pend;

endmodule

// File: doc/log_perf_ctrl.md
Name: log_perf_ctrl

Overview:
Simulation-only control source for the log/perf infrastructure, instantiated in the simulation top. Generates the free-running difftest cycle timer, the windowed log-enable flag, and single-cycle perf-counter clean/dump strobes. Its outputs drive the top-level difftest_timer, difftest_log_enable, difftest_perfCtrl_clean and difftest_perfCtrl_dump nets, which every per-module perf/log helper samples.

Parameters:
TIMER_W, 64, width of cycle timer and log window bounds
INTERVAL_W, 32, width of periodic dump interval and its counter

Ports:
clock  input  1  single clock; all state on rising edge
reset  input  1  synchronous, active-low (0 = reset)
timer_en  input  1  timer/interval counting enable; 0 freezes both
log_begin  input  TIMER_W  first timer value with logging on (inclusive)
log_end  input  TIMER_W  timer value at which logging turns off (exclusive)
perf_interval  input  INTERVAL_W  periodic dump+clean period in counted cycles; 0 disables periodic events
perf_dump_req  input  1  host dump request, one-cycle pulse or level
perf_clean_req  input  1  host clean request, one-cycle pulse or level
timer  output  TIMER_W  cycle timer
log_enable  output  1  logging window active
perf_clean  output  1  one-cycle clean strobe
perf_dump  output  1  one-cycle dump strobe
perf_busy  output  1  strobe sequence in progress or pending

Behaviour:
- Reset (reset==0 at clock edge): timer=0, interval counter=0, state=IDLE, dump_pend=clean_pend=0; all outputs 0. Mid-sequence reset aborts the sequence and drops pending requests; no strobe is emitted in the cycle after reset.
- Timer: timer_en=1 increments by 1 per cycle; saturates at all-ones (no wrap). timer_en=0 holds.
- log_enable: registered; computed from next timer value so that in every cycle log_enable == (timer >= log_begin) && (timer < log_end), unsigned compare. log_end <= log_begin => never enabled. Bound changes take effect the following cycle.
- Interval counter: counts while timer_en=1 and perf_interval!=0. When counter >= perf_interval-1 and timer_en=1, the periodic event fires: counter clears to 0 and both dump_pend and clean_pend are set. The >= compare makes lowering perf_interval below the current count fire on the next counted cycle. perf_interval=0 holds the counter at 0.
- Pending flags: pend_next = (pend & ~consumed) | new_req, where new_req = the host request or the periodic event. A request arriving in the cycle its flag is consumed re-arms it (one extra strobe, never lost).
- FSM (Moore; strobes are registered state decodes):
  IDLE -> DUMP if dump_pend; else -> CLEAN if clean_pend; else stay.
  DUMP (perf_dump=1, consumes dump_pend) -> CLEAN if clean_pend (including one set this cycle), else IDLE.
  CLEAN (perf_clean=1, consumes clean_pend) -> IDLE.
- Ordering: dump always precedes clean when both are pending, so counters are read before being zeroed. Strobes never overlap; each lasts exactly one cycle.
- Latency: a request sampled at edge N from IDLE gives its strobe high in cycle N+1. Dump+clean gives perf_dump in N+1 and perf_clean in N+2.
- Requests arriving while not IDLE only set pending; they are served after the current sequence returns to IDLE, with at least one IDLE cycle between sequences.
- Level requests re-trigger continuously. Hosts pulse for a single event.
- perf_busy = (state != IDLE) | dump_pend | clean_pend.

Test Plan:
- Reset release, timer_en=1 for 10 cycles -> timer 0..10; all other outputs 0. Assert reset at timer=5 -> timer=0 next cycle.
- log_begin=3, log_end=6 -> log_enable=1 exactly in the cycles where timer is 3, 4 and 5. Set log_begin=6, log_end=6 -> log_enable stays 0.
- perf_interval=4, timer_en=1 -> periodic event every 4 counted cycles: perf_dump pulses, perf_clean the next cycle. Hold timer_en=0 for 3 cycles mid-period -> event delayed 3 cycles.
- perf_dump_req and perf_clean_req pulsed in the same cycle -> dump in N+1, clean in N+2, perf_busy 1 for N+1..N+2 only. A lone perf_clean_req -> clean only, in N+1.
- perf_dump_req pulse during a CLEAN cycle -> IDLE, then a single perf_dump; no lost or duplicate strobe. Reset asserted during DUMP -> no perf_clean follows.
- Timer preloaded via force to all-ones minus 1 -> saturates at all-ones and holds.
